// File: rtl/demux_reg3_if.sv
// Bus bundle for the registered 1-to-3 demultiplexer: the producer-side write/ack
// controls and the three holding registers with their valid and overwrite status.
interface demux_reg3_if #(
  parameter int DATA_WIDTH = 32
);
  logic [2:0]            selector;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  write;
  logic [2:0]            ack;
  logic [DATA_WIDTH-1:0] data_0;
  logic [DATA_WIDTH-1:0] data_1;
  logic [DATA_WIDTH-1:0] data_2;
  logic [2:0]            valid;
  logic                  overwrite;

  modport master (
    output selector, data_in, write, ack,
    input  data_0, data_1, data_2, valid, overwrite
  );

  modport slave (
    input  selector, data_in, write, ack,
    output data_0, data_1, data_2, valid, overwrite
  );
endinterface

// File: rtl/demux_reg3.sv
// Registered 1-to-3 demultiplexer: routes a datapath word into one of three holding
// registers, tracks per-slot valid flags cleared by ack, and flags unacked overwrites.
module demux_reg3 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  demux_reg3_if.slave  bus
);

  logic [2:0]            dest_oh_s;
  logic [2:0]            wr_oh_s;
  logic [DATA_WIDTH-1:0] data_0_d, data_1_d, data_2_d;
  logic [DATA_WIDTH-1:0] data_0_q, data_1_q, data_2_q;
  logic [2:0]            valid_d, valid_q;
  logic                  overwrite_d, overwrite_q;

  // Selector decode; unused codes fall back to dest 0 like the 3-way selectors.
  always_comb begin
    dest_oh_s = 3'b001;
    case (bus.selector)
      3'b001:  dest_oh_s = 3'b010;
      3'b010:  dest_oh_s = 3'b100;
      default: dest_oh_s = 3'b001;
    endcase
  end

  // Next-state: a write to a slot beats a same-cycle ack on that slot.
  always_comb begin
    wr_oh_s     = bus.write ? dest_oh_s : 3'b000;
    valid_d     = (valid_q & ~bus.ack) | wr_oh_s;
    overwrite_d = overwrite_q | (|(wr_oh_s & valid_q & ~bus.ack));
    data_0_d    = data_0_q;
    data_1_d    = data_1_q;
    data_2_d    = data_2_q;
    if (wr_oh_s[0]) begin
      data_0_d = bus.data_in;
    end else begin
      data_0_d = data_0_q;
    end
    if (wr_oh_s[1]) begin
      data_1_d = bus.data_in;
    end else begin
      data_1_d = data_1_q;
    end
    if (wr_oh_s[2]) begin
      data_2_d = bus.data_in;
    end else begin
      data_2_d = data_2_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_0_q    <= {DATA_WIDTH{1'b0}};
      data_1_q    <= {DATA_WIDTH{1'b0}};
      data_2_q    <= {DATA_WIDTH{1'b0}};
      valid_q     <= 3'b000;
      overwrite_q <= 1'b0;
    end else begin
      data_0_q    <= data_0_d;
      data_1_q    <= data_1_d;
      data_2_q    <= data_2_d;
      valid_q     <= valid_d;
      overwrite_q <= overwrite_d;
    end
  end

  assign bus.data_0    = data_0_q;
  assign bus.data_1    = data_1_q;
  assign bus.data_2    = data_2_q;
  assign bus.valid     = valid_q;
  assign bus.overwrite = overwrite_q;

endmodule

// File: tb/tb_demux_reg3.sv
// Self-checking bench for demux_reg3: directed routing/ack/overwrite/reset steps,
// then randomized traffic against a slot-level reference model.
module tb_demux_reg3;

  localparam int DW = 32;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [DW-1:0] m_data [3];
  logic [2:0]    m_valid;
  logic          m_ov;

  demux_reg3_if #(.DATA_WIDTH(DW)) bus ();

  demux_reg3 #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.write && $isunknown(bus.selector)))
        else $error("FAIL sel_x: selector unknown while write=1");
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".data_0"},    bus.data_0, m_data[0]);
    check({tag, ".data_1"},    bus.data_1, m_data[1]);
    check({tag, ".data_2"},    bus.data_2, m_data[2]);
    check({tag, ".valid"},     {29'd0, bus.valid}, {29'd0, m_valid});
    check({tag, ".overwrite"}, {31'd0, bus.overwrite}, {31'd0, m_ov});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_data[i] = '0;
    m_valid = 3'b000;
    m_ov    = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic step(input logic wr, input logic [2:0] sel, input logic [DW-1:0] din,
                      input logic [2:0] ak, input string tag);
    int d;
    bus.write    = wr;
    bus.selector = sel;
    bus.data_in  = din;
    bus.ack      = ak;
    d = (sel == 3'd1) ? 1 : ((sel == 3'd2) ? 2 : 0);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (wr && d == i) begin
        if (m_valid[i] && !ak[i]) m_ov = 1'b1;
        m_data[i]  = din;
        m_valid[i] = 1'b1;
      end else if (ak[i]) begin
        m_valid[i] = 1'b0;
      end
    end
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_model("reset_async");
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.write = 1'b0; bus.selector = 3'b000; bus.data_in = '0; bus.ack = 3'b000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset_init");
    reset = 1'b0;

    // Routing, one cycle per destination
    step(1'b1, 3'b000, 32'hAAAA0000, 3'b000, "route0");
    check("route0_const", bus.data_0, 32'hAAAA0000);
    step(1'b1, 3'b001, 32'hBBBB0001, 3'b000, "route1");
    check("route1_const", bus.data_1, 32'hBBBB0001);
    step(1'b1, 3'b010, 32'hCCCC0002, 3'b000, "route2");
    check("route2_const", bus.data_2, 32'hCCCC0002);
    check("valid_all", {29'd0, bus.valid}, 32'd7);

    // Async reset mid-cycle with all slots valid, then refill
    do_reset();
    check("reset_valid_const", {29'd0, bus.valid}, 32'd0);
    step(1'b1, 3'b000, 32'hAAAA0000, 3'b000, "refill0");
    step(1'b1, 3'b001, 32'hBBBB0001, 3'b000, "refill1");
    step(1'b1, 3'b010, 32'hCCCC0002, 3'b000, "refill2");

    // Default code 111 lands in dest 0 (ack[0] makes it a clean hand-off)
    step(1'b1, 3'b111, 32'h12345678, 3'b001, "default_code");
    check("default_const", bus.data_0, 32'h12345678);
    check("default_d1", bus.data_1, 32'hBBBB0001);
    check("default_ov", {31'd0, bus.overwrite}, 32'd0);

    // Ack of slots 0 and 2; data must survive
    step(1'b0, 3'b000, 32'hFFFFFFFF, 3'b101, "ack101");
    check("ack_valid_const", {29'd0, bus.valid}, 32'd2);
    check("ack_d2_kept", bus.data_2, 32'hCCCC0002);
    step(1'b0, 3'b000, 32'h0, 3'b101, "ack_invalid_ignored");

    // Overwrite into unacked slot 1, sticky until reset
    step(1'b1, 3'b001, 32'hDEADBEEF, 3'b000, "overwrite");
    check("ov_d1_const", bus.data_1, 32'hDEADBEEF);
    check("ov_set_const", {31'd0, bus.overwrite}, 32'd1);
    step(1'b0, 3'b000, 32'h0, 3'b111, "ov_sticky_a");
    step(1'b0, 3'b000, 32'h0, 3'b000, "ov_sticky_b");
    check("ov_sticky_const", {31'd0, bus.overwrite}, 32'd1);

    // Hand-off: write with same-cycle ack is legal
    do_reset();
    step(1'b1, 3'b001, 32'h11111111, 3'b000, "handoff_fill");
    step(1'b1, 3'b001, 32'hDEADBEEF, 3'b010, "handoff");
    check("handoff_ov_const", {31'd0, bus.overwrite}, 32'd0);
    check("handoff_valid1", {31'd0, bus.valid[1]}, 32'd1);

    // Randomized traffic with occasional mid-run reset
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom),
             3'($urandom_range(0, 7)), "random");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
